sme_job_sequencer: RTL and testbench
====================================

# sme_job_sequencer

Upstream feeder for the SME string-matching engine: accepts string and pattern bytes over a valid/ready byte stream and replays them one byte per cycle on the engine's `chardata`/`isstring`/`ispattern` loading interface. It waits for the engine's `valid`, captures `match`/`match_index`, and returns the result over a valid/ready result port. Only one job is in flight at a time. Frame-length and framing errors are flagged rather than forwarded.

## Interface
- `BYTE`, 8, character width
- `MAX_STRING`, 32, maximum string length in characters
- `MAX_PATTERN`, 8, maximum pattern length in characters
- `MAX_STR_ADD`, 5, string index width, equal to clog2(`MAX_STRING`)
- `TIMEOUT_CYC`, 1024, watchdog limit (see Configuration)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous assert, active-low, released synchronously to `clk`
- `in_data` in `BYTE`: input character
- `in_kind` in 1: 0 = string byte, 1 = pattern byte
- `in_last` in 1: last byte of the current frame
- `in_valid` in 1 / `in_ready` out 1: input handshake
- `chardata` out `BYTE`: to SME
- `isstring` out 1, `ispattern` out 1: to SME
- `sme_valid` in 1, `sme_match` in 1, `sme_match_index` in `MAX_STR_ADD`: from SME
- `res_valid` out 1 / `res_ready` in 1: result handshake
- `res_match` out 1, `res_index` out `MAX_STR_ADD`, `res_err` out 1: result payload
- `busy` out 1: asserted in any state except IDLE

## Operation
- FSM states: IDLE, STR, PAT, GAP, WAIT, RESP.
- IDLE:
  - `in_ready`=1.
  - An accepted byte with `in_kind`=0 moves to STR and is forwarded.
  - An accepted byte with `in_kind`=1 is dropped and sets the sticky error bit; the state stays IDLE.
- STR:
  - `in_ready`=1 and string bytes are forwarded.
  - A string byte with `in_last` moves to PAT.
  - A pattern byte arriving in STR sets error, is forwarded as a pattern byte, and moves to PAT (or to GAP if `in_last`).
- PAT:
  - Pattern bytes are forwarded; a byte with `in_last` moves to GAP.
  - A string byte arriving in PAT is dropped and sets error.
- Length counters:
  - `str_cnt` counts 0..`MAX_STRING`; `pat_cnt` counts 0..`MAX_PATTERN`.
  - A byte beyond the maximum is accepted but not forwarded (`isstring`/`ispattern` stay 0) and sets error.
  - Counters saturate; they never wrap.
- GAP: one cycle with `isstring`=`ispattern`=0 so the engine sees end of load. Then move to WAIT; `in_ready`=0.
- WAIT:
  - `in_ready`=0.
  - On `sme_valid`=1, capture `sme_match` and `sme_match_index` into the result registers, set `res_err` from the sticky error bit, and move to RESP.
- RESP:
  - `res_valid`=1, with payload held stable.
  - On `res_ready`=1, clear the error bit and both counters and move to IDLE.
- `sme_valid` outside WAIT is ignored.

## Timing
- Reset values:
  - Outputs: `in_ready`=0 during reset, 1 in the first cycle after release; `chardata`=0; `isstring`=0; `ispattern`=0; `res_valid`=0; `res_match`=0; `res_index`=0; `res_err`=0; `busy`=0.
  - Internal: state IDLE, counters 0, error bit 0.
- Forwarding latency: a byte accepted at edge N appears on `chardata`/`isstring`/`ispattern` for exactly the cycle after edge N. Strobes are registered; no combinational path runs from `in_*` to the SME outputs.
- `in_ready` is a registered function of state only. A handshake on the last pattern byte makes `in_ready` 0 in the following cycle.
- Pattern-last byte to WAIT: the byte drives for 1 cycle, then GAP for 1 cycle, then WAIT.
- `sme_valid` sampled at edge N gives `res_valid`=1 after edge N.
- Back-to-back jobs:
  - The result handshake at edge N puts the block in IDLE after edge N.
  - A new byte can be accepted at edge N+1.
- Reset mid-job: all state is discarded immediately. Any partial SME load is abandoned, and SME must be reset by the same `reset`.

## Configuration
- `SME_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - After `TIMEOUT_CYC` cycles without `sme_valid`, move to RESP with `res_err`=1, `res_match`=0, `res_index`=0.
- `SME_SEQ_TIMEOUT_EN` undefined: no counter; WAIT waits indefinitely.

## Structure
- A shared package/include holds the FSM state encoding, the `BYTE`/`MAX_*` defaults (reusing the existing spec-parameter include), and a `KIND_STR`/`KIND_PAT` constant.
- One natural sub-module, `sme_seq_len_guard`: the saturating length counters plus the overflow/error flag logic, instantiated once.

## Test plan
- String "ABCAB" (last on 'B'), then pattern "CA" -> `isstring`=1 for 5 consecutive cycles, GAP cycle, `ispattern`=1 for 2 cycles. Model `sme_valid` with match=1, index=2 -> `res_valid` with `res_match`=1, `res_index`=2, `res_err`=0.
- Pattern byte sent while IDLE -> dropped, no strobe. The following valid job completes with `res_err`=1.
- 34-byte string -> only 32 `isstring` cycles, `res_err`=1. The following clean job reports `res_err`=0, showing the error bit was cleared.
- Hold `res_ready`=0 for 10 cycles in RESP -> payload stable, `in_ready`=0. Release -> next job is accepted the cycle after the handshake.
- `SME_SEQ_TIMEOUT_EN` with `TIMEOUT_CYC`=16 and no `sme_valid` -> `res_valid` after 16 WAIT cycles with `res_err`=1.
- Assert `reset` low during PAT -> all outputs at reset values asynchronously. After release, a fresh job completes normally.

Source files
------------

// File: rtl/sme_job_sequencer_pkg.sv
// Shared definitions for the SME job sequencer: FSM encoding, size defaults, byte-kind codes.
package sme_job_sequencer_pkg;

    localparam int SEQ_BYTE        = 8;
    localparam int SEQ_MAX_STRING  = 32;
    localparam int SEQ_MAX_PATTERN = 8;
    localparam int SEQ_MAX_STR_ADD = 5;
    localparam int SEQ_TIMEOUT_CYC = 1024;

    localparam logic KIND_STR = 1'b0;
    localparam logic KIND_PAT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STR,
        ST_PAT,
        ST_GAP,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

    // States in which the byte stream may be accepted.
    function automatic logic state_accepts(seq_state_e s);
        return (s == ST_IDLE) || (s == ST_STR) || (s == ST_PAT);
    endfunction

endpackage

// File: rtl/sme_job_sequencer_if.sv
// Byte stream in, SME load/result signals and result port of the job sequencer.
interface sme_job_sequencer_if
    import sme_job_sequencer_pkg::*;
#(
    parameter int BYTE        = SEQ_BYTE,
    parameter int MAX_STR_ADD = SEQ_MAX_STR_ADD
);
    logic [BYTE-1:0]        in_data;
    logic                   in_kind;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [BYTE-1:0]        chardata;
    logic                   isstring;
    logic                   ispattern;
    logic                   sme_valid;
    logic                   sme_match;
    logic [MAX_STR_ADD-1:0] sme_match_index;
    logic                   res_valid;
    logic                   res_ready;
    logic                   res_match;
    logic [MAX_STR_ADD-1:0] res_index;
    logic                   res_err;
    logic                   busy;

    modport slave (
        input  in_data, in_kind, in_last, in_valid,
               sme_valid, sme_match, sme_match_index, res_ready,
        output in_ready, chardata, isstring, ispattern,
               res_valid, res_match, res_index, res_err, busy
    );

    modport master (
        output in_data, in_kind, in_last, in_valid,
               sme_valid, sme_match, sme_match_index, res_ready,
        input  in_ready, chardata, isstring, ispattern,
               res_valid, res_match, res_index, res_err, busy
    );

endinterface

// File: rtl/sme_seq_len_guard.sv
// Saturating string/pattern length counters and the sticky job error flag.
module sme_seq_len_guard
    import sme_job_sequencer_pkg::*;
#(
    parameter int MAX_STRING  = SEQ_MAX_STRING,
    parameter int MAX_PATTERN = SEQ_MAX_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic str_inc_i,
    input  logic pat_inc_i,
    input  logic frame_err_i,
    input  logic clr_i,
    output logic str_room_o,
    output logic pat_room_o,
    output logic err_o
);
    localparam int SW = $clog2(MAX_STRING + 1);
    localparam int PW = $clog2(MAX_PATTERN + 1);

    logic [SW-1:0] str_cnt_q, str_cnt_d;
    logic [PW-1:0] pat_cnt_q, pat_cnt_d;
    logic          err_q, err_d;

    assign str_room_o = (str_cnt_q < SW'(MAX_STRING));
    assign pat_room_o = (pat_cnt_q < PW'(MAX_PATTERN));
    assign err_o      = err_q;

    // An over-length byte leaves its counter parked at the maximum and flags the job.
    always_comb begin
        str_cnt_d = str_cnt_q;
        pat_cnt_d = pat_cnt_q;
        err_d     = err_q;
        if (clr_i) begin
            str_cnt_d = '0;
            pat_cnt_d = '0;
            err_d     = 1'b0;
        end else begin
            if (str_inc_i) begin
                if (str_room_o) str_cnt_d = str_cnt_q + 1'b1;
                else            err_d     = 1'b1;
            end
            if (pat_inc_i) begin
                if (pat_room_o) pat_cnt_d = pat_cnt_q + 1'b1;
                else            err_d     = 1'b1;
            end
            if (frame_err_i) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            str_cnt_q <= '0;
            pat_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            str_cnt_q <= str_cnt_d;
            pat_cnt_q <= pat_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/sme_job_sequencer.sv
// Feeds one string+pattern job at a time into the SME and returns its result.
// Optional WAIT watchdog: define SME_SEQ_TIMEOUT_EN.
module sme_job_sequencer
    import sme_job_sequencer_pkg::*;
#(
    parameter int BYTE        = SEQ_BYTE,
    parameter int MAX_STRING  = SEQ_MAX_STRING,
    parameter int MAX_PATTERN = SEQ_MAX_PATTERN,
    parameter int MAX_STR_ADD = SEQ_MAX_STR_ADD,
    parameter int TIMEOUT_CYC = SEQ_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    sme_job_sequencer_if.slave  bus
);
    seq_state_e             state_q, state_d;
    logic                   in_ready_q;
    logic [BYTE-1:0]        chardata_q, chardata_d;
    logic                   isstring_q, isstring_d;
    logic                   ispattern_q, ispattern_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_match_q, res_match_d;
    logic [MAX_STR_ADD-1:0] res_index_q, res_index_d;
    logic                   res_err_q, res_err_d;

    logic accept, timeout;
    logic str_inc, pat_inc, frame_err, cnt_clr;
    logic str_room, pat_room, err_flag;

    assign accept = bus.in_valid & in_ready_q;

    sme_seq_len_guard #(
        .MAX_STRING  (MAX_STRING),
        .MAX_PATTERN (MAX_PATTERN)
    ) u_len_guard (
        .clk         (clk),
        .reset       (reset),
        .str_inc_i   (str_inc),
        .pat_inc_i   (pat_inc),
        .frame_err_i (frame_err),
        .clr_i       (cnt_clr),
        .str_room_o  (str_room),
        .pat_room_o  (pat_room),
        .err_o       (err_flag)
    );

`ifdef SME_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    wdog_q <= '0;
        else if (state_q != ST_WAIT || bus.sme_valid)  wdog_q <= '0;
        else                                           wdog_q <= wdog_q + 1'b1;
    end

    // Fires on the last of TIMEOUT_CYC consecutive WAIT cycles without an engine result.
    assign timeout = (state_q == ST_WAIT) && !bus.sme_valid &&
                     (wdog_q == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        chardata_d  = chardata_q;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        res_valid_d = res_valid_q;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        res_err_d   = res_err_q;
        str_inc     = 1'b0;
        pat_inc     = 1'b0;
        frame_err   = 1'b0;
        cnt_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.in_kind == KIND_STR) begin
                        str_inc    = 1'b1;
                        isstring_d = str_room;
                        state_d    = bus.in_last ? ST_PAT : ST_STR;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            ST_STR: begin
                if (accept) begin
                    if (bus.in_kind == KIND_STR) begin
                        str_inc    = 1'b1;
                        isstring_d = str_room;
                        if (bus.in_last) state_d = ST_PAT;
                    end else begin
                        // Missing string terminator: keep loading, but as the pattern.
                        frame_err   = 1'b1;
                        pat_inc     = 1'b1;
                        ispattern_d = pat_room;
                        state_d     = bus.in_last ? ST_GAP : ST_PAT;
                    end
                end
            end
            ST_PAT: begin
                if (accept) begin
                    if (bus.in_kind == KIND_PAT) begin
                        pat_inc     = 1'b1;
                        ispattern_d = pat_room;
                        if (bus.in_last) state_d = ST_GAP;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            ST_GAP: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.sme_valid) begin
                    res_valid_d = 1'b1;
                    res_match_d = bus.sme_match;
                    res_index_d = bus.sme_match_index;
                    res_err_d   = err_flag;
                    state_d     = ST_RESP;
                end else if (timeout) begin
                    res_valid_d = 1'b1;
                    res_match_d = 1'b0;
                    res_index_d = '0;
                    res_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    cnt_clr     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (isstring_d || ispattern_d) chardata_d = bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            chardata_q  <= '0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_accepts(state_d);
            chardata_q  <= chardata_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.chardata  = chardata_q;
    assign bus.isstring  = isstring_q;
    assign bus.ispattern = ispattern_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_match = res_match_q;
    assign bus.res_index = res_index_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sme_job_sequencer.sv
// Directed job table plus hand sequences for reset, stray SME strobes and the watchdog.
module tb_sme_job_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sme_job_sequencer_if #(.BYTE(8), .MAX_STR_ADD(5)) bus ();

    sme_job_sequencer #(
        .BYTE        (8),
        .MAX_STRING  (32),
        .MAX_PATTERN (8),
        .MAX_STR_ADD (5),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      str;
        string      pat;
        int         stray;   // 0 none, 1 pattern byte in IDLE, 2 string byte in PAT, 3 no string last
        bit         no_sme;
        logic       m;
        logic [4:0] idx;
        int         hold;
        int         e_nstr;
        int         e_npat;
        logic       e_m;
        logic [4:0] e_idx;
        logic       e_err;
    } job_t;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sq[$];
    logic [7:0] pq[$];

    always @(negedge clk) begin
        if (bus.isstring)  sq.push_back(bus.chardata);
        if (bus.ispattern) pq.push_back(bus.chardata);
    end

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] d, input logic k, input logic l, output int stall);
        stall = 0;
        bus.in_data = d; bus.in_kind = k; bus.in_last = l; bus.in_valid = 1'b1;
        while (!bus.in_ready && stall < 50) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 50) chk("send", "in_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input job_t v, input string tag);
        int st;
        int k;
        sq.delete();
        pq.delete();
        if (v.stray == 1) begin
            send_byte(8'h5A, 1'b1, 1'b0, st);
            chk(tag, "stray_idle_busy", bus.busy, 1'b0);
        end
        for (int i = 0; i < v.str.len(); i++) begin
            send_byte(v.str[i], 1'b0, (i == v.str.len() - 1) && (v.stray != 3), st);
            if (i == 0) chk(tag, "first_byte_stall", st, 0);
        end
        for (int i = 0; i < v.pat.len(); i++) begin
            send_byte(v.pat[i], 1'b1, i == v.pat.len() - 1, st);
            if (i == 0 && v.stray == 2) send_byte(8'h51, 1'b0, 1'b0, st);
        end
        chk(tag, "in_ready_after_last", bus.in_ready, 1'b0);
        @(negedge clk);
        chk(tag, "gap_strobes", {bus.isstring, bus.ispattern}, 2'b00);
        if (v.no_sme) begin
            k = 0;
            while (!bus.res_valid && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk(tag, "timeout_wait_cycles", k, 16);
        end else begin
            chk(tag, "res_valid_before", bus.res_valid, 1'b0);
            bus.sme_valid = 1'b1; bus.sme_match = v.m; bus.sme_match_index = v.idx;
            @(negedge clk);
            bus.sme_valid = 1'b0; bus.sme_match = 1'b0; bus.sme_match_index = '0;
            chk(tag, "res_valid_latency", bus.res_valid, 1'b1);
        end
        chk(tag, "res_match", bus.res_match, v.e_m);
        chk(tag, "res_index", bus.res_index, v.e_idx);
        chk(tag, "res_err", bus.res_err, v.e_err);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk(tag, "hold_stable", {bus.res_valid, bus.res_match, bus.res_index, bus.res_err, bus.in_ready},
                {1'b1, v.e_m, v.e_idx, v.e_err, 1'b0});
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk(tag, "post_handshake", {bus.res_valid, bus.busy, bus.in_ready}, 3'b001);
        chk(tag, "isstring_count", sq.size(), v.e_nstr);
        chk(tag, "ispattern_count", pq.size(), v.e_npat);
        for (int i = 0; i < sq.size() && i < v.str.len(); i++) chk(tag, "str_byte", sq[i], v.str[i]);
        for (int i = 0; i < pq.size() && i < v.pat.len(); i++) chk(tag, "pat_byte", pq[i], v.pat[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        job_t jobs[11];
        int   st;
        jobs[0]  = '{"ABCAB", "CA", 0, 1'b0, 1'b1, 5'd2, 0, 5, 2, 1'b1, 5'd2, 1'b0};
        jobs[1]  = '{"HELLO", "LL", 1, 1'b0, 1'b1, 5'd2, 0, 5, 2, 1'b1, 5'd2, 1'b1};
        jobs[2]  = '{"abcdefghijklmnopqrstuvwxyz01234567", "xy", 0, 1'b0, 1'b0, 5'd0, 0, 32, 2, 1'b0, 5'd0, 1'b1};
        jobs[3]  = '{"QRS", "R", 0, 1'b0, 1'b1, 5'd1, 10, 3, 1, 1'b1, 5'd1, 1'b0};
        jobs[4]  = '{"MNOP", "OP", 0, 1'b0, 1'b1, 5'd2, 0, 4, 2, 1'b1, 5'd2, 1'b0};
        jobs[5]  = '{"AB", "CD", 3, 1'b0, 1'b1, 5'd31, 0, 2, 2, 1'b1, 5'd31, 1'b1};
        jobs[6]  = '{"0123456789ABCDEFGHIJKLMNOPQRSTUV", "abcdefgh", 0, 1'b0, 1'b0, 5'd0, 0, 32, 8, 1'b0, 5'd0, 1'b0};
        jobs[7]  = '{"XYZ", "0123456789", 0, 1'b0, 1'b0, 5'd0, 0, 3, 8, 1'b0, 5'd0, 1'b1};
        jobs[8]  = '{"AAA", "BB", 2, 1'b0, 1'b1, 5'd7, 0, 3, 2, 1'b1, 5'd7, 1'b1};
        jobs[9]  = '{"FRESH", "SH", 0, 1'b0, 1'b1, 5'd3, 0, 5, 2, 1'b1, 5'd3, 1'b0};
        jobs[10] = '{"TO", "T", 0, 1'b1, 1'b1, 5'd9, 0, 2, 1, 1'b0, 5'd0, 1'b1};

        reset = 1'b0;
        bus.in_data = '0; bus.in_kind = 1'b0; bus.in_last = 1'b0; bus.in_valid = 1'b0;
        bus.sme_valid = 1'b0; bus.sme_match = 1'b0; bus.sme_match_index = '0; bus.res_ready = 1'b0;
        #12;
        chk("reset", "outputs_in_reset",
            {bus.in_ready, bus.chardata, bus.isstring, bus.ispattern, bus.res_valid,
             bus.res_match, bus.res_index, bus.res_err, bus.busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset", "in_ready_after_release", {bus.in_ready, bus.busy}, 2'b10);

        for (int i = 0; i < 9; i++) run_job(jobs[i], $sformatf("job%0d", i));

        // SME strobe while idle must not produce a result or disturb the held payload.
        bus.sme_valid = 1'b1; bus.sme_match = 1'b0; bus.sme_match_index = 5'd9;
        @(negedge clk);
        bus.sme_valid = 1'b0; bus.sme_match_index = '0;
        @(negedge clk);
        chk("idle_sme", "ignored", {bus.res_valid, bus.busy, bus.res_match, bus.res_index},
            {1'b0, 1'b0, 1'b1, 5'd7});

        // Abort a job in PAT (with a pending framing error) by asserting reset between edges.
        send_byte(8'h5A, 1'b1, 1'b0, st);
        send_byte(8'h58, 1'b0, 1'b0, st);
        send_byte(8'h59, 1'b0, 1'b1, st);
        send_byte(8'h50, 1'b1, 1'b0, st);
        chk("midreset", "pat_driving", {bus.ispattern, bus.chardata, bus.busy}, {1'b1, 8'h50, 1'b1});
        #2 reset = 1'b0;
        #1;
        chk("midreset", "outputs_async",
            {bus.in_ready, bus.chardata, bus.isstring, bus.ispattern, bus.res_valid,
             bus.res_match, bus.res_index, bus.res_err, bus.busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset", "in_ready_after_release", bus.in_ready, 1'b1);
        run_job(jobs[9], "job9_post_reset");

`ifdef SME_SEQ_TIMEOUT_EN
        run_job(jobs[10], "job10_timeout");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
